// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus: debug enable, hazard holds, ID redirects, loader port and IF/ID outputs.
// The master is the surrounding pipeline/debug logic; the slave is the fetch stage.
interface if_stage_fetch_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
);
  logic               i_enable;
  logic               i_pc_hold;
  logic               i_if_id_hold;
  logic               i_branch_taken;
  logic [NB_DATA-1:0] i_branch_target;
  logic               i_jump;
  logic [NB_DATA-1:0] i_jump_target;
  logic               i_wr_en;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data;
  logic [NB_DATA-1:0] o_pc;
  logic [NB_DATA-1:0] o_if_id_pc4;
  logic [NB_DATA-1:0] o_if_id_instr;
  logic               o_if_id_valid;
  logic               o_halted;

  modport master (
    output i_enable, i_pc_hold, i_if_id_hold, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_wr_en, i_wr_addr, i_wr_data,
    input  o_pc, o_if_id_pc4, o_if_id_instr, o_if_id_valid, o_halted
  );

  modport slave (
    input  i_enable, i_pc_hold, i_if_id_hold, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_wr_en, i_wr_addr, i_wr_data,
    output o_pc, o_if_id_pc4, o_if_id_instr, o_if_id_valid, o_halted
  );
endinterface

// File: rtl/if_stage_fetch.sv
// MIPS instruction-fetch stage: PC register, loader-written instruction memory,
// IF/ID pipeline register and HALT detection that drains the pipeline.
module if_stage_fetch #(
  parameter int               NB_DATA     = 32,
  parameter int               NB_ADDR     = 10,
  parameter logic [NB_DATA-1:0] RESET_PC  = '0,
  parameter logic [5:0]       HALT_OPCODE = 6'b111111
) (
  input  logic            i_clock,
  input  logic            i_reset,
  if_stage_fetch_if.slave bus
);
  localparam int MEM_DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [NB_ADDR-1:0] fetch_addr;
  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] pc_plus4;
  logic               redirect_accept;

  // Loader writes land at the edge, so a same-cycle fetch of that word still sees old data.
  always_ff @(posedge i_clock) begin
    if (bus.i_wr_en) begin
      mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  assign fetch_addr = pc_q[NB_ADDR+1:2];
  assign fetch_word = mem[fetch_addr];
  assign pc_plus4   = pc_q + NB_DATA'(4);

  // A redirect only counts when the PC actually moves; under a PC hold it re-resolves later.
  assign redirect_accept = !bus.i_pc_hold && !halted_q && (bus.i_branch_taken || bus.i_jump);

  always_comb begin
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (bus.i_enable) begin
      if (!bus.i_pc_hold && !halted_q) begin
        if (bus.i_branch_taken) begin
          pc_d = bus.i_branch_target;
        end else if (bus.i_jump) begin
          pc_d = bus.i_jump_target;
        end else begin
          pc_d = pc_plus4;
        end
      end
      if (!bus.i_if_id_hold) begin
        if (redirect_accept) begin
          instr_d = '0;
          valid_d = 1'b0;
          pc4_d   = pc_plus4;
        end else if (halted_q) begin
          instr_d = '0;
          valid_d = 1'b0;
        end else begin
          instr_d = fetch_word;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (fetch_word[NB_DATA-1 -: 6] == HALT_OPCODE) begin
            halted_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      pc4_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_if_id_pc4   = pc4_q;
  assign bus.o_if_id_instr = instr_q;
  assign bus.o_if_id_valid = valid_q;
  assign bus.o_halted      = halted_q;
endmodule
